// File: rtl/instr_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the instruction decode stage.
// valid/ready: a transfer happens on a rising clk where valid && ready; the source holds its payload stable until then.
interface instr_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [15:0] out_imm;
  logic [31:0] out_pc;
  logic        out_itype;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm, out_pc, out_itype
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm, out_pc, out_itype
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Two-entry skid buffer between fetch and execute that slices the held instruction into fields.
// in_ready depends only on registered state, so out_ready never reaches in_ready combinationally.
module instr_decode_stage (
  input  logic              clk,
  input  logic              rst_n,
  instr_decode_if.slave     bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] h_instr, h_pc;
  logic [31:0] s_instr, s_pc;
  logic        load_h, load_s, h_from_s;
  logic        accept, pop;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_h    = 1'b0;
    load_s    = 1'b0;
    h_from_s  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_h    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_h = 1'b1;
        end else if (accept) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          h_from_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A redirect wins over everything, including an instruction handshaken this cycle.
    if (bus.flush) begin
      state_nxt = EMPTY;
      load_h    = 1'b0;
      load_s    = 1'b0;
      h_from_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_instr <= '0;
      h_pc    <= '0;
      s_instr <= '0;
      s_pc    <= '0;
    end else begin
      if (load_h) begin
        h_instr <= bus.in_instr;
        h_pc    <= bus.in_pc;
      end else if (h_from_s) begin
        h_instr <= s_instr;
        h_pc    <= s_pc;
      end
      if (load_s) begin
        s_instr <= bus.in_instr;
        s_pc    <= bus.in_pc;
      end
    end
  end

  // Fields are gated so a stale head never leaks out while nothing is valid.
  assign bus.out_opcode = bus.out_valid ? h_instr[31:26] : 6'd0;
  assign bus.out_rs     = bus.out_valid ? h_instr[25:21] : 5'd0;
  assign bus.out_rt     = bus.out_valid ? h_instr[20:16] : 5'd0;
  assign bus.out_imm    = bus.out_valid ? h_instr[15:0]  : 16'd0;
  assign bus.out_pc     = bus.out_valid ? h_pc           : 32'd0;
  assign bus.out_itype  = bus.out_valid && (h_instr[31:26] != 6'd0);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus random traffic against a capacity-2 FIFO model.
module tb_instr_decode_stage;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  instr_decode_if bus ();

  instr_decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [63:0] exp_q[$];   // {pc, instr}, head at index 0
  int n_vec;
  int n_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [68:0] model_outputs();
    logic [31:0] ins;
    logic [31:0] pc;
    logic        v;
    v   = (exp_q.size() > 0);
    ins = v ? exp_q[0][31:0]  : 32'd0;
    pc  = v ? exp_q[0][63:32] : 32'd0;
    return {v, exp_q.size() < 2, ins[31:26], ins[25:21], ins[20:16], ins[15:0], pc,
            v && (ins[31:26] != 6'd0), 2'(exp_q.size())};
  endfunction

  function automatic logic [68:0] dut_outputs();
    return {bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm,
            bus.out_pc, bus.out_itype, dbg_state};
  endfunction

  task automatic compare_all(input string name);
    logic [68:0] e, a;
    e = model_outputs();
    a = dut_outputs();
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: the model decides from pre-edge inputs, then outputs are checked 1ns after the edge.
  task automatic step(input string name);
    bit acc, pop, fl;
    logic [63:0] ent;
    acc = bus.in_valid && (exp_q.size() < 2);
    pop = (exp_q.size() > 0) && bus.out_ready;
    fl  = bus.flush;
    ent = {bus.in_pc, bus.in_instr};
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ent);
    end
    #1;
    compare_all(name);
  endtask

  logic [31:0] a_ins, b_ins, c_ins;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3;
    compare_all("reset_state");
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all("post_reset");

    // Single pass with an I-type whose immediate is negative
    drive(1'b1, 32'h2401_8001, 32'h0000_0040, 1'b1, 1'b0);
    step("single_pass");
    chk("sp_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("sp_opcode", {26'd0, bus.out_opcode}, 32'h09);
    chk("sp_rs",     {27'd0, bus.out_rs}, 32'd0);
    chk("sp_rt",     {27'd0, bus.out_rt}, 32'd1);
    chk("sp_imm",    {16'd0, bus.out_imm}, 32'h8001);
    chk("sp_sext",   {{16{bus.out_imm[15]}}, bus.out_imm}, 32'hFFFF_8001);
    chk("sp_itype",  {31'd0, bus.out_itype}, 32'd1);
    chk("sp_pc",     bus.out_pc, 32'h0000_0040);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step("sp_drain");

    // Backpressure: A, B accepted, C stalled, then all three drain in order
    a_ins = 32'h2000_00A1; b_ins = 32'h2000_00B2; c_ins = 32'h2000_00C3;
    drive(1'b1, a_ins, 32'h100, 1'b0, 1'b0); step("bp_a");
    drive(1'b1, b_ins, 32'h104, 1'b0, 1'b0); step("bp_b");
    drive(1'b1, c_ins, 32'h108, 1'b0, 1'b0);
    chk("bp_c_stalled", {31'd0, bus.in_ready}, 32'd0);
    step("bp_hold1");
    step("bp_hold2");
    chk("bp_head_a", {16'd0, bus.out_imm}, 32'h00A1);
    drive(1'b1, c_ins, 32'h108, 1'b1, 1'b0); step("bp_pop_a");
    chk("bp_head_b", {16'd0, bus.out_imm}, 32'h00B2);
    step("bp_accept_c");
    chk("bp_head_c", {16'd0, bus.out_imm}, 32'h00C3);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step("bp_pop_c");
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Streaming: one in, one out per cycle
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, {16'h2000, 16'(k)}, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
      step("stream");
      chk("stream_imm", {16'd0, bus.out_imm}, 32'(k));
      chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step("stream_drain");

    // Flush from FULL with a simultaneous handshake
    drive(1'b1, 32'h2000_1111, 32'h300, 1'b0, 1'b0); step("fl_fill1");
    drive(1'b1, 32'h2000_2222, 32'h304, 1'b0, 1'b0); step("fl_fill2");
    drive(1'b1, 32'h2000_3333, 32'h308, 1'b1, 1'b1); step("fl_flush");
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step("fl_idle1");
    step("fl_idle2");

    // Asynchronous reset while FULL, between edges
    drive(1'b1, 32'h2000_4444, 32'h400, 1'b0, 1'b0); step("ar_fill1");
    drive(1'b1, 32'h2000_5555, 32'h404, 1'b0, 1'b0); step("ar_fill2");
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("ar_imm",   {16'd0, bus.out_imm}, 32'd0);
    compare_all("ar_all");
    #1 rst_n = 1'b1;
    drive(1'b1, 32'h2000_6666, 32'h500, 1'b1, 1'b0);
    step("ar_first_accept");
    chk("ar_first_imm", {16'd0, bus.out_imm}, 32'h6666);

    // R-type
    drive(1'b1, 32'h0022_0820, 32'h600, 1'b1, 1'b0);
    step("rtype");
    chk("rt_opcode", {26'd0, bus.out_opcode}, 32'd0);
    chk("rt_itype",  {31'd0, bus.out_itype}, 32'd0);
    chk("rt_imm",    {16'd0, bus.out_imm}, 32'h0820);
    chk("rt_rs",     {27'd0, bus.out_rs}, 32'd1);
    chk("rt_rt",     {27'd0, bus.out_rt}, 32'd2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? {6'd0, 26'($urandom)} : $urandom,
            $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
